// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: default 800x600 mode, derived totals and output widths.
// Imported by vga_timing_gen, vga_axis_counter users and display_monitor.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE_DEF = 800;
    localparam int unsigned H_FP_DEF      = 56;
    localparam int unsigned H_SYNC_DEF    = 120;
    localparam int unsigned H_BP_DEF      = 64;
    localparam int unsigned V_VISIBLE_DEF = 600;
    localparam int unsigned V_FP_DEF      = 37;
    localparam int unsigned V_SYNC_DEF    = 6;
    localparam int unsigned V_BP_DEF      = 23;

    localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // 480000 active pixels, last line index 665
    localparam int unsigned PIXELS_DEF = H_VISIBLE_DEF * V_VISIBLE_DEF;
    localparam int unsigned V_LAST_DEF = V_TOTAL_DEF - 1;

    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned PIX_W = 20;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with carry-out, plus visible
// and sync-window decodes of the current count.
module vga_axis_counter #(
    parameter int unsigned W          = 11,
    parameter int unsigned TOTAL      = 1040,
    parameter int unsigned VISIBLE    = 800,
    parameter int unsigned SYNC_START = 856,
    parameter int unsigned SYNC_END   = 976
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         zero_o,
    output logic         visible_o,
    output logic         sync_o
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_END = W'(VISIBLE);
    localparam logic [W-1:0] S_START = W'(SYNC_START);
    localparam logic [W-1:0] S_END   = W'(SYNC_END);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Carry is qualified by enable so a vertical instance only wraps on a line wrap
    assign wrap_o    = en_i && (count_q == LAST);
    assign zero_o    = (count_q == '0);
    assign visible_o = (count_q < VIS_END);
    assign sync_o    = (count_q >= S_START) && (count_q < S_END);
    assign count_o   = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered sync/visible/pulse
// decodes and a linear active-pixel index, all with one cycle of latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic             rst,
    input  logic             vga_clk,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             line,
    output logic             frame,
    output logic [PIX_W-1:0] pixel,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [PIX_W-1:0] IDX_LAST = PIX_W'(H_VISIBLE * V_VISIBLE - 1);

    logic [X_W-1:0] h;
    logic [Y_W-1:0] v;
    logic h_wrap, h_zero, h_vis, h_sync;
    logic v_wrap, v_zero, v_vis, v_sync;

    vga_axis_counter #(
        .W(X_W), .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
        .SYNC_START(H_VISIBLE + H_FP), .SYNC_END(H_VISIBLE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk_i(vga_clk), .rst_i(rst), .en_i(1'b1),
        .count_o(h), .wrap_o(h_wrap), .zero_o(h_zero),
        .visible_o(h_vis), .sync_o(h_sync)
    );

    vga_axis_counter #(
        .W(Y_W), .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
        .SYNC_START(V_VISIBLE + V_FP), .SYNC_END(V_VISIBLE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk_i(vga_clk), .rst_i(rst), .en_i(h_wrap),
        .count_o(v), .wrap_o(v_wrap), .zero_o(v_zero),
        .visible_o(v_vis), .sync_o(v_sync)
    );

    logic [PIX_W-1:0] idx_q, idx_d;
    logic             vis_now;

    assign vis_now = h_vis && v_vis;

    // Index advances after each active pixel; forced to 0 at frame end as a resync
    always_comb begin
        idx_d = idx_q;
        if (v_wrap) begin
            idx_d = '0;
        end else if (vis_now) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + PIX_W'(1);
        end
    end

    logic             hsync_q, vsync_q, visible_q, line_q, frame_q;
    logic [PIX_W-1:0] pixel_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            visible_q <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            pixel_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            idx_q     <= idx_d;
            hsync_q   <= h_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync_q   <= v_sync ? VSYNC_POL : ~VSYNC_POL;
            visible_q <= vis_now;
            line_q    <= h_zero;
            frame_q   <= h_zero && v_zero;
            pixel_q   <= idx_q;
            x_q       <= h;
            y_q       <= v;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign visible = visible_q;
    assign line    = line_q;
    assign frame   = frame_q;
    assign pixel   = pixel_q;
    assign x       = x_q;
    assign y       = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance for line-level timing, plus two
// reduced-size instances (normal and inverted sync polarity) for whole frames.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  always #10 vga_clk = ~vga_clk;

  logic rst_d, rst_s;

  logic        hsync_d, vsync_d, visible_d, line_d, frame_d;
  logic [19:0] pixel_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;

  logic        hsync_s, vsync_s, visible_s, line_s, frame_s;
  logic [19:0] pixel_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;

  logic        hsync_n, vsync_n, visible_n, line_n, frame_n;
  logic [19:0] pixel_n;
  logic [10:0] x_n;
  logic [9:0]  y_n;

  int checks = 0;
  int passed = 0;

  vga_timing_gen dut_d (
    .rst(rst_d), .vga_clk(vga_clk), .hsync(hsync_d), .vsync(vsync_d),
    .visible(visible_d), .line(line_d), .frame(frame_d),
    .pixel(pixel_d), .x(x_d), .y(y_d)
  );

  // Small mode: H 8+2+3+2 = 15 clocks, V 6+2+2+1 = 11 lines, 48 active pixels
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .rst(rst_s), .vga_clk(vga_clk), .hsync(hsync_s), .vsync(vsync_s),
    .visible(visible_s), .line(line_s), .frame(frame_s),
    .pixel(pixel_s), .x(x_s), .y(y_s)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_n (
    .rst(rst_s), .vga_clk(vga_clk), .hsync(hsync_n), .vsync(vsync_n),
    .visible(visible_n), .line(line_n), .frame(frame_n),
    .pixel(pixel_n), .x(x_n), .y(y_n)
  );

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) step();
    checks++;
    if ({hsync_d, vsync_d, visible_d, line_d, frame_d} !== 5'b00000)
      $display("FAIL reset_flags_default got %b exp 00000", {hsync_d, vsync_d, visible_d, line_d, frame_d});
    else passed++;
    checks++;
    if ({pixel_d, x_d, y_d} !== 41'd0)
      $display("FAIL reset_pos_default got pixel=%0d x=%0d y=%0d exp 0", pixel_d, x_d, y_d);
    else passed++;
    checks++;
    if ({hsync_n, vsync_n, visible_n, line_n, frame_n} !== 5'b11000)
      $display("FAIL reset_flags_inverted got %b exp 11000", {hsync_n, vsync_n, visible_n, line_n, frame_n});
    else passed++;
    @(negedge vga_clk) rst_d = 1'b0;
    step();
    checks++;
    if ({hsync_d, vsync_d, visible_d, line_d, frame_d} !== 5'b00111)
      $display("FAIL first_edge_flags got %b exp 00111", {hsync_d, vsync_d, visible_d, line_d, frame_d});
    else passed++;
    checks++;
    if ({pixel_d, x_d, y_d} !== 41'd0)
      $display("FAIL first_edge_pos got pixel=%0d x=%0d y=%0d exp 0", pixel_d, x_d, y_d);
    else passed++;
    checks++;
    if ({visible_s, line_s, frame_s} !== 3'b000)
      $display("FAIL small_held_in_reset got %b exp 000", {visible_s, line_s, frame_s});
    else passed++;
  endtask

  // Walks line 0 of the default mode: x, hsync window, visible, pixel index
  task automatic test_line0();
    logic [10:0] ex;
    logic        ehs, evis;
    logic [19:0] epix;
    for (int n = 1; n < 1040; n++) begin
      step();
      ex   = 11'(n);
      ehs  = (n >= 856) && (n < 976);
      evis = (n < 800);
      epix = (n < 800) ? 20'(n) : 20'd800;
      checks++;
      if ({x_d, y_d, hsync_d, vsync_d, visible_d, line_d, frame_d, pixel_d} !==
          {ex, 10'd0, ehs, 1'b0, evis, 1'b0, 1'b0, epix})
        $display("FAIL line0_h%0d got x=%0d y=%0d hs=%b vs=%b vis=%b ln=%b fr=%b pix=%0d exp hs=%b vis=%b pix=%0d",
                 n, x_d, y_d, hsync_d, vsync_d, visible_d, line_d, frame_d, pixel_d, ehs, evis, epix);
      else passed++;
      if (n == 855 || n == 856 || n == 975 || n == 976) begin
        checks++;
        if (hsync_d !== ehs) $display("FAIL hsync_at_h%0d got %b exp %b", n, hsync_d, ehs);
        else passed++;
      end
    end
  endtask

  task automatic test_line1_start();
    step();
    checks++;
    if ({x_d, y_d, line_d, frame_d, visible_d, pixel_d} !== {11'd0, 10'd1, 1'b1, 1'b0, 1'b1, 20'd800})
      $display("FAIL line1_start got x=%0d y=%0d ln=%b fr=%b vis=%b pix=%0d exp 0 1 1 0 1 800",
               x_d, y_d, line_d, frame_d, visible_d, pixel_d);
    else passed++;
    repeat (5) step();
    checks++;
    if ({x_d, pixel_d} !== {11'd5, 20'd805})
      $display("FAIL line1_x5 got x=%0d pix=%0d exp 5 805", x_d, pixel_d);
    else passed++;
  endtask

  // One full frame of the small mode against a bench-side raster model
  task automatic test_frame_small();
    int lines = 0, frames = 0, vis_cnt = 0;
    int h, v;
    logic        ehs, evs, evis, eln, efr;
    logic [19:0] epix;
    @(negedge vga_clk) rst_s = 1'b0;
    for (int c = 0; c < 165; c++) begin
      step();
      h    = c % 15;
      v    = c / 15;
      ehs  = (h >= 10) && (h < 13);
      evs  = (v >= 8) && (v < 10);
      evis = (h < 8) && (v < 6);
      eln  = (h == 0);
      efr  = (h == 0) && (v == 0);
      if (v >= 6)     epix = 20'd0;
      else if (h < 8) epix = 20'(v * 8 + h);
      else            epix = 20'(((v + 1) * 8) % 48);
      lines   += int'(line_s);
      frames  += int'(frame_s);
      vis_cnt += int'(visible_s);
      checks++;
      if ({x_s, y_s, hsync_s, vsync_s, visible_s, line_s, frame_s, pixel_s} !==
          {11'(h), 10'(v), ehs, evs, evis, eln, efr, epix})
        $display("FAIL small_c%0d got x=%0d y=%0d hs=%b vs=%b vis=%b ln=%b fr=%b pix=%0d exp x=%0d y=%0d hs=%b vs=%b vis=%b ln=%b fr=%b pix=%0d",
                 c, x_s, y_s, hsync_s, vsync_s, visible_s, line_s, frame_s, pixel_s,
                 h, v, ehs, evs, evis, eln, efr, epix);
      else passed++;
      checks++;
      if ({hsync_n, vsync_n} !== {~ehs, ~evs})
        $display("FAIL inverted_sync_c%0d got hs=%b vs=%b exp hs=%b vs=%b", c, hsync_n, vsync_n, ~ehs, ~evs);
      else passed++;
    end
    checks++;
    if (lines !== 11) $display("FAIL line_pulses got %0d exp 11", lines);
    else passed++;
    checks++;
    if (frames !== 1) $display("FAIL frame_pulses got %0d exp 1", frames);
    else passed++;
    checks++;
    if (vis_cnt !== 48) $display("FAIL visible_cycles got %0d exp 48", vis_cnt);
    else passed++;
    step();
    checks++;
    if ({frame_s, line_s, visible_s, pixel_s, x_s, y_s} !== {3'b111, 20'd0, 11'd0, 10'd0})
      $display("FAIL frame2_start got fr=%b ln=%b vis=%b pix=%0d x=%0d y=%0d exp 1 1 1 0 0 0",
               frame_s, line_s, visible_s, pixel_s, x_s, y_s);
    else passed++;
  endtask

  task automatic test_midframe_reset();
    repeat (49) step();
    checks++;
    if ({x_s, y_s, visible_s, pixel_s} !== {11'd4, 10'd3, 1'b1, 20'd28})
      $display("FAIL pre_reset_pos got x=%0d y=%0d vis=%b pix=%0d exp 4 3 1 28", x_s, y_s, visible_s, pixel_s);
    else passed++;
    @(negedge vga_clk) rst_s = 1'b1;
    #1;
    checks++;
    if ({hsync_s, vsync_s, visible_s, line_s, frame_s, pixel_s, x_s, y_s} !== 46'd0)
      $display("FAIL async_abort got hs=%b vs=%b vis=%b ln=%b fr=%b pix=%0d x=%0d y=%0d exp all 0",
               hsync_s, vsync_s, visible_s, line_s, frame_s, pixel_s, x_s, y_s);
    else passed++;
    repeat (3) step();
    checks++;
    if ({hsync_n, vsync_n, visible_n} !== 3'b110)
      $display("FAIL inverted_in_reset got %b exp 110", {hsync_n, vsync_n, visible_n});
    else passed++;
    @(negedge vga_clk) rst_s = 1'b0;
    step();
    checks++;
    if ({visible_s, line_s, frame_s, pixel_s, x_s, y_s} !== {3'b111, 20'd0, 11'd0, 10'd0})
      $display("FAIL restart_first got vis=%b ln=%b fr=%b pix=%0d x=%0d y=%0d exp 1 1 1 0 0 0",
               visible_s, line_s, frame_s, pixel_s, x_s, y_s);
    else passed++;
    step();
    checks++;
    if ({x_s, y_s, pixel_s, line_s} !== {11'd1, 10'd0, 20'd1, 1'b0})
      $display("FAIL restart_second got x=%0d y=%0d pix=%0d ln=%b exp 1 0 1 0", x_s, y_s, pixel_s, line_s);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_line0();
    test_line1_start();
    test_frame_small();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL expose these parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SYNC, 120, hsync width (clocks)
- H_BP, 64, horizontal back porch (clocks)
- V_VISIBLE, 600, active lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, hsync asserted level
- VSYNC_POL, 1, vsync asserted level

REQ-002 The block SHALL have these ports:
- rst  in  1  reset, asynchronous, active-high
- vga_clk  in  1  clock, 50 MHz pixel clock
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- visible  out  1  current pixel is in the active area
- line  out  1  one-cycle pulse at the start of every line
- frame  out  1  one-cycle pulse at the start of every frame
- pixel  out  20  linear index of the next active pixel, y*H_VISIBLE+x
- x  out  11  horizontal position counter
- y  out  10  vertical position counter

Function
REQ-003 Horizontal counter h SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters, default 1040), increment every vga_clk and wrap to 0.
REQ-004 Vertical counter v SHALL run 0..V_TOTAL-1 (default 666); it SHALL increment only when h wraps, and wrap to 0 when h and v both wrap.
REQ-005 All outputs SHALL be registered decodes of (h,v), giving exactly 1 cycle latency; all outputs SHALL be mutually aligned.
REQ-006 visible SHALL be 1 iff h < H_VISIBLE and v < V_VISIBLE.
REQ-007 hsync SHALL equal HSYNC_POL iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC (default 856..975), and ~HSYNC_POL otherwise.
REQ-008 vsync SHALL equal VSYNC_POL iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC (default 637..642), and ~VSYNC_POL otherwise; it SHALL change only at h=0.
REQ-009 line SHALL be 1 for exactly one cycle when h=0, for every v, including blank lines (666 pulses per frame).
REQ-010 frame SHALL be 1 for exactly one cycle when h=0 and v=0; frame and line SHALL coincide at that cycle.
REQ-011 An internal index counter SHALL be output as pixel; it SHALL increment by 1 after each visible cycle and wrap from H_VISIBLE*V_VISIBLE-1 (479999) to 0; it SHALL hold during blanking.
REQ-012 pixel SHALL therefore be 0 throughout vertical blanking and at the first visible pixel, and (v+1)*800 throughout the h-blank of active line v.
REQ-013 x SHALL equal h and y SHALL equal v, both registered with the other outputs.
REQ-014 Arithmetic SHALL be unsigned; the widths of x, y and pixel SHALL cover the default totals with no overflow.

Reset
REQ-015 While rst=1: h=0, v=0, index=0; hsync=~HSYNC_POL, vsync=~VSYNC_POL; visible, line and frame = 0; pixel, x and y = 0.
REQ-016 The first vga_clk edge after rst is released SHALL output the decode of (0,0): visible=1, line=1, frame=1, pixel=0.
REQ-017 Assertion of rst mid-frame SHALL abort immediately, with no partial line or frame completion after release.

Structure
REQ-018 The default timing constants and derived H_TOTAL/V_TOTAL SHALL live in a shared vga_timing package, used by vga_timing_gen and display_monitor (480000, 665).
REQ-019 One sub-module SHALL be used: vga_axis_counter (a wrap counter with a carry-out and a sync-window decode), instantiated once for the horizontal axis and once for the vertical axis.

Verification
REQ-020 Release reset, then run 1 frame (692640 clocks) -> exactly 666 line pulses, 1 frame pulse, and 480000 visible cycles.
REQ-021 Sample at h=855/856/975/976 -> hsync = 0/1/1/0 (default polarity).
REQ-022 Track pixel -> it equals y*800+x whenever visible=1; it is 800 during the h-blank of line 0; it reads 479999 at (799,599) and then 0.
REQ-023 Rebuild with HSYNC_POL=0 and VSYNC_POL=0 -> the sync levels are inverted, and the vsync low window covers lines 637..642.
REQ-024 Assert rst at (h=400, v=300) for 3 clocks, then release -> the next outputs are visible=1, frame=1, pixel=0, x=0, y=0.
